mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 138 +++++++++++++
 tb/tb_mdu.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide on magnitudes.
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mdop,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] p_q, p_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        in_sgn, in_sa, in_sb;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [33:0] div_diff;
  logic        div_take;
  logic [63:0] prod_neg;
  logic [31:0] q_neg, r_neg;

  assign in_sgn = ~mdop[0];
  assign in_sa  = in_sgn & srca[31];
  assign in_sb  = in_sgn & srcb[31];
  assign a_mag  = in_sa ? -srca : srca;
  assign b_mag  = in_sb ? -srcb : srcb;

  // p_q holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
  assign mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, b_q} : 33'd0);
  assign div_diff = {1'b0, p_q[63:31]} - {2'b00, b_q};
  assign div_take = ~div_diff[33];

  assign prod_neg = -p_q;
  assign q_neg    = -p_q[31:0];
  assign r_neg    = -p_q[63:32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d    = mdop;
          sa_d    = in_sa;
          sb_d    = in_sb;
          a_d     = srca;
          b_d     = b_mag;
          p_d     = {32'd0, a_mag};
          cnt_d   = 5'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (op_q[1]) p_d = div_take ? {div_diff[31:0], p_q[30:0], 1'b1}
                                    : {p_q[62:31], p_q[30:0], 1'b0};
        else         p_d = {mul_sum, p_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = SIGN;
      end
      SIGN: begin
        if (!op_q[1]) begin
          {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : p_q;
        end else if (b_q == 32'd0) begin
          hi_d = a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          lo_d = (sa_q ^ sb_q) ? q_neg : p_q[31:0];
          hi_d = sa_q ? r_neg : p_q[63:32];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      p_q     <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus random operations
// against an arithmetic reference model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mdop;
  logic [31:0] srca, srcb;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic [31:0] hi, lo;
  logic        busy, done;

  int nassert = 0;
  int nfail   = 0;

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop),
    .srca(srca), .srcb(srcb), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (op)
      2'd0: res = sa * sb;
      2'd1: res = ua * ub;
      2'd2: if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin sq = sa / sb; sr = sa % sb; res = {sr[31:0], sq[31:0]}; end
      default: if (b == 0) res = {a, 32'hFFFF_FFFF};
               else begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
    endcase
    return res;
  endfunction

  // Caller is 1 time unit after an edge; start is driven here and seen at the next edge (E0).
  // inj>0 pulses start and hi_we so they are sampled at edge E<inj>.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inj, input logic [32:0] pre_hi);
    logic [63:0] e;
    logic [31:0] h0, l0;
    bit ok_busy, ok_hold, got;
    e = ref_md(op, a, b);
    start = 1'b1; mdop = op; srca = a; srcb = b;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    srca = $urandom; srcb = $urandom; mdop = 2'($urandom);
    chk({nm, ".busy_e0"}, 64'(busy), 64'd1);
    chk({nm, ".done_e0"}, 64'(done), 64'd0);
    if (pre_hi[32]) chk({nm, ".hi_we_with_start"}, 64'(hi), 64'(pre_hi[31:0]));
    h0 = hi; l0 = lo;
    ok_busy = 1'b1; ok_hold = 1'b1; got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (k == inj) begin start = 1'b1; hi_we = 1'b1; wdata = 32'hA5A5_A5A5; end
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0;
      if (done) begin
        got = 1'b1;
        chk({nm, ".done_edge"}, 64'(k), 64'd33);
        chk({nm, ".busy_at_done"}, 64'(busy), 64'd0);
        chk({nm, ".hi"}, 64'(hi), 64'(e[63:32]));
        chk({nm, ".lo"}, 64'(lo), 64'(e[31:0]));
      end else begin
        if (!busy) ok_busy = 1'b0;
        if (hi !== h0 || lo !== l0) ok_hold = 1'b0;
      end
    end
    if (!got) chk({nm, ".done_timeout"}, 64'd0, 64'd1);
    chk({nm, ".busy_while_calc"}, 64'(ok_busy), 64'd1);
    chk({nm, ".hilo_hold"}, 64'(ok_hold), 64'd1);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b1; mdop = 2'd1; srca = 32'd5; srcb = 32'd6;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    @(posedge clk); #1;

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 33'd0);
    // issued in the done cycle: must be accepted
    run_op("mult_m3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 0, 33'd0);
    run_op("div_m7d2",  2'd2, 32'hFFFF_FFF9, 32'd2, 0, 33'd0);
    run_op("divu_7d2",  2'd3, 32'd7, 32'd2, 0, 33'd0);
    run_op("div_by0",   2'd2, 32'h1234_5678, 32'd0, 0, 33'd0);
    run_op("divu_by0",  2'd3, 32'h8765_4321, 32'd0, 0, 33'd0);
    run_op("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 33'd0);
    run_op("div_negrem", 2'd2, 32'd7, 32'hFFFF_FFFE, 0, 33'd0);
    run_op("multu_6x7_inj", 2'd1, 32'd6, 32'd7, 10, 33'd0);
    @(posedge clk); #1;
    chk("single_done", 64'(done), 64'd0);

    lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk("lo_we_idle", 64'(lo), 64'h5A5A_5A5A);

    hi_we = 1'b1; wdata = 32'h0BAD_F00D;
    run_op("mult_with_hi_we", 2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0, {1'b1, 32'h0BAD_F00D});

    // abandon a DIVU with reset at E10
    start = 1'b1; mdop = 2'd3; srca = 32'd1000; srcb = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("midreset.busy", 64'(busy), 64'd0);
    chk("midreset.hi", 64'(hi), 64'd0);
    chk("midreset.lo", 64'(lo), 64'd0);
    chk("midreset.done", 64'(done), 64'd0);
    begin
      bit saw = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done) saw = 1'b1;
      end
      chk("midreset.no_done", 64'(saw), 64'd0);
    end
    run_op("divu_100d7", 2'd3, 32'd100, 32'd7, 0, 33'd0);

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom);
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, 0, 33'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
